// File: rtl/hazard_fwd_unit.sv
// Hazard detection for the 5-stage ARM pipeline: tracks in-flight destinations,
// raises IF/ID stall/flush and produces registered EXE forwarding selects.
module hazard_fwd_unit #(
    parameter int unsigned RA_W  = 4,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned SEL_W = $clog2(DEPTH),
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_src1,
    input  logic [RA_W-1:0]  id_src2,
    input  logic             id_two_src,
    input  logic [RA_W-1:0]  id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r,
    input  logic             id_s,
    input  logic             id_reads_sr,
    input  logic             br_taken,
    output logic             stall,
    output logic             flush,
    output logic [SEL_W-1:0] fwd_sel1,
    output logic [SEL_W-1:0] fwd_sel2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] fwd_cnt
);

    // The WB entry is never matched, so only entries 0..DEPTH-2 are stored;
    // load and status bits only matter at entry 0.
    logic [DEPTH-2:0] v_q;
    logic [DEPTH-2:0] wb_q;
    logic [RA_W-1:0]  dest_q [DEPTH-1];
    logic             ld0_q;
    logic             s0_q;

    logic             hit1, hit2, lu1, lu2, sr_haz, haz, issue;
    logic [SEL_W-1:0] sel1_c, sel2_c;

    // Walk from oldest to youngest so the lowest matching k wins.
    always_comb begin
        hit1   = 1'b0;
        hit2   = 1'b0;
        lu1    = 1'b0;
        lu2    = 1'b0;
        sel1_c = '0;
        sel2_c = '0;
        for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
            if (v_q[k] && wb_q[k] && dest_q[k] == id_src1) begin
                hit1   = 1'b1;
                lu1    = (k == 0) && ld0_q;
                sel1_c = SEL_W'(k + 1);
            end
            if (id_two_src && v_q[k] && wb_q[k] && dest_q[k] == id_src2) begin
                hit2   = 1'b1;
                lu2    = (k == 0) && ld0_q;
                sel2_c = SEL_W'(k + 1);
            end
        end
        if (!fwd_en) begin
            sel1_c = '0;
            sel2_c = '0;
        end
        sr_haz = id_reads_sr && v_q[0] && s0_q;
        haz    = fwd_en ? (lu1 || lu2) : (hit1 || hit2);
        stall  = rst && id_valid && !br_taken && (haz || sr_haz);
        flush  = br_taken;
        issue  = id_valid && !stall && !br_taken;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q       <= '0;
            wb_q      <= '0;
            ld0_q     <= 1'b0;
            s0_q      <= 1'b0;
            fwd_sel1  <= '0;
            fwd_sel2  <= '0;
            stall_cnt <= '0;
            fwd_cnt   <= '0;
            for (int k = 0; k < int'(DEPTH) - 1; k++) begin
                dest_q[k] <= '0;
            end
        end else begin
            v_q[0]    <= issue;
            wb_q[0]   <= id_wb_en;
            dest_q[0] <= id_dest;
            ld0_q     <= id_mem_r;
            s0_q      <= id_s;
            for (int k = 1; k < int'(DEPTH) - 1; k++) begin
                v_q[k]    <= v_q[k-1];
                wb_q[k]   <= wb_q[k-1];
                dest_q[k] <= dest_q[k-1];
            end
            fwd_sel1 <= issue ? sel1_c : '0;
            fwd_sel2 <= issue ? sel2_c : '0;
            if (stall && stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (issue && (sel1_c != '0 || sel2_c != '0) && fwd_cnt != {CNT_W{1'b1}}) begin
                fwd_cnt <= fwd_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: directed instruction sequences with
// hand-derived stall/select expectations and a saturating counter model.
module tb_hazard_fwd_unit;

    localparam int unsigned RA_W  = 4;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             fwd_en = 1'b0;
    logic             id_valid = 1'b0;
    logic [RA_W-1:0]  id_src1 = '0;
    logic [RA_W-1:0]  id_src2 = '0;
    logic             id_two_src = 1'b0;
    logic [RA_W-1:0]  id_dest = '0;
    logic             id_wb_en = 1'b0;
    logic             id_mem_r = 1'b0;
    logic             id_s = 1'b0;
    logic             id_reads_sr = 1'b0;
    logic             br_taken = 1'b0;
    logic             stall, flush;
    logic [SEL_W-1:0] fwd_sel1, fwd_sel2;
    logic [CNT_W-1:0] stall_cnt, fwd_cnt;

    hazard_fwd_unit #(
        .RA_W (RA_W),
        .DEPTH(DEPTH),
        .SEL_W(SEL_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fwd_en     (fwd_en),
        .id_valid   (id_valid),
        .id_src1    (id_src1),
        .id_src2    (id_src2),
        .id_two_src (id_two_src),
        .id_dest    (id_dest),
        .id_wb_en   (id_wb_en),
        .id_mem_r   (id_mem_r),
        .id_s       (id_s),
        .id_reads_sr(id_reads_sr),
        .br_taken   (br_taken),
        .stall      (stall),
        .flush      (flush),
        .fwd_sel1   (fwd_sel1),
        .fwd_sel2   (fwd_sel2),
        .stall_cnt  (stall_cnt),
        .fwd_cnt    (fwd_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s1;
        int s2;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   exp_stalls = 0;
    int   exp_fwds = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sat(input int n);
        return (n >= (2 ** CNT_W) - 1) ? 32'((2 ** CNT_W) - 1) : 32'(n);
    endfunction

    task automatic idle_inputs();
        id_valid    = 1'b0;
        id_two_src  = 1'b0;
        id_wb_en    = 1'b0;
        id_mem_r    = 1'b0;
        id_s        = 1'b0;
        id_reads_sr = 1'b0;
        br_taken    = 1'b0;
    endtask

    // Assert reset with whatever is on the ID inputs, then release it.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check({tag, "_stall_in_rst"}, 32'(stall), 32'd0);
        check({tag, "_flush_in_rst"}, 32'(flush), 32'(br_taken));
        @(posedge clk);
        #1;
        check({tag, "_sel1_rst"}, 32'(fwd_sel1), 32'd0);
        check({tag, "_sel2_rst"}, 32'(fwd_sel2), 32'd0);
        check({tag, "_scnt_rst"}, 32'(stall_cnt), 32'd0);
        check({tag, "_fcnt_rst"}, 32'(fwd_cnt), 32'd0);
        rst = 1'b1;
        idle_inputs();
        exp_stalls = 0;
        exp_fwds   = 0;
        sb.delete();
    endtask

    // One ID cycle: drive, check combinational controls, push the expected
    // selects, clock, then pop and compare against the registered selects.
    task automatic issue(input string tag, input logic v, input logic [3:0] s1,
                         input logic [3:0] s2, input logic two, input logic [3:0] d,
                         input logic wb, input logic ld, input logic s, input logic rsr,
                         input logic br, input logic es, input int e1, input int e2);
        exp_t e;
        id_valid    = v;
        id_src1     = s1;
        id_src2     = s2;
        id_two_src  = two;
        id_dest     = d;
        id_wb_en    = wb;
        id_mem_r    = ld;
        id_s        = s;
        id_reads_sr = rsr;
        br_taken    = br;
        #1;
        check({tag, "_stall"}, 32'(stall), 32'(es));
        check({tag, "_flush"}, 32'(flush), 32'(br));
        if (v && !es && !br) begin
            sb.push_back('{e1, e2});
            if (e1 != 0 || e2 != 0) exp_fwds++;
        end else begin
            sb.push_back('{0, 0});
        end
        if (es) exp_stalls++;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, "_sel1"}, 32'(fwd_sel1), 32'(e.s1));
        check({tag, "_sel2"}, 32'(fwd_sel2), 32'(e.s2));
        check({tag, "_scnt"}, 32'(stall_cnt), sat(exp_stalls));
        check({tag, "_fcnt"}, 32'(fwd_cnt), sat(exp_fwds));
    endtask

    task automatic filler(input string tag);
        issue(tag, 1, 9, 9, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        idle_inputs();
        #2;
        do_reset("init");

        // Stall-only mode: ADD r1 ; SUB r2,r1,r3
        fwd_en = 1'b0;
        do_reset("so");
        issue("so_add",  1, 10, 11, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        issue("so_sub0", 1,  1,  3, 1, 2, 1, 0, 0, 0, 0, 1, 0, 0);
        issue("so_sub1", 1,  1,  3, 1, 2, 1, 0, 0, 0, 0, 1, 0, 0);
        issue("so_sub2", 1,  1,  3, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        check("so_stall_cnt", 32'(stall_cnt), 32'd2);

        // Forwarding: distance 1, 2, 3 and youngest-wins
        fwd_en = 1'b1;
        do_reset("fw");
        issue("fw_add",   1, 10, 11, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        issue("fw_d1",    1,  1,  1, 1, 2, 1, 0, 0, 0, 0, 0, 1, 1);
        issue("fw_add2",  1, 10, 11, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        filler("fw_f1");
        issue("fw_d2",    1,  1,  3, 1, 2, 1, 0, 0, 0, 0, 0, 2, 0);
        issue("fw_add3",  1, 10, 11, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        filler("fw_f2");
        filler("fw_f3");
        issue("fw_d3",    1,  1,  3, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        issue("fw_ya",    1, 10, 11, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        issue("fw_yb",    1, 10, 11, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        issue("fw_young", 1,  1,  3, 1, 2, 1, 0, 0, 0, 0, 0, 1, 0);
        issue("fw_p",     1, 10, 11, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        issue("fw_nosrc2",1,  3,  1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        check("fw_fwd_cnt", 32'(fwd_cnt), 32'd3);

        // Load-use
        do_reset("lu");
        issue("lu_ldr",  1, 10,  0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0);
        issue("lu_add0", 1,  4,  6, 1, 5, 1, 0, 0, 0, 0, 1, 0, 0);
        issue("lu_add1", 1,  4,  6, 1, 5, 1, 0, 0, 0, 0, 0, 2, 0);
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        check("lu_fwd_cnt", 32'(fwd_cnt), 32'd1);

        // Reset in the middle of a load-use stall
        do_reset("mr");
        issue("mr_ldr", 1, 10, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0);
        id_valid   = 1'b1;
        id_src1    = 4'd4;
        id_src2    = 4'd6;
        id_two_src = 1'b1;
        id_dest    = 4'd5;
        id_wb_en   = 1'b1;
        id_mem_r   = 1'b0;
        #1;
        check("mr_pre_stall", 32'(stall), 32'd1);
        do_reset("mr");
        issue("mr_after", 1, 4, 6, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);

        // Status hazard in both modes
        for (int m = 0; m < 2; m++) begin
            fwd_en = m[0];
            do_reset("sr");
            issue("sr_cmp",  1, 1, 2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
            issue("sr_eq0",  1, 3, 4, 1, 5, 1, 0, 0, 1, 0, 1, 0, 0);
            issue("sr_eq1",  1, 3, 4, 1, 5, 1, 0, 0, 1, 0, 0, 0, 0);
        end
        // Load-use and status together count once
        issue("srl_ldrs", 1, 10, 0, 0, 4, 1, 1, 1, 0, 0, 0, 0, 0);
        issue("srl_use0", 1,  4, 6, 1, 5, 1, 0, 0, 1, 0, 1, 0, 0);
        issue("srl_use1", 1,  4, 6, 1, 5, 1, 0, 0, 1, 0, 0, 2, 0);
        check("srl_stall_cnt", 32'(stall_cnt), 32'd2);

        // Taken branch during a pending load-use
        do_reset("br");
        issue("br_ldr",  1, 10, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0);
        issue("br_kill", 1,  4, 6, 1, 5, 1, 0, 0, 0, 1, 0, 0, 0);
        issue("br_next", 1,  5, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
        check("br_stall_cnt", 32'(stall_cnt), 32'd0);

        // Counter saturation: ADD r1,r1 repeated stalls 2 of every 3 cycles
        fwd_en = 1'b0;
        do_reset("sat");
        for (int i = 0; i < 30; i++) begin
            issue("sat", 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, (i % 3) != 0, 0, 0);
        end
        check("sat_final", 32'(stall_cnt), 32'((2 ** CNT_W) - 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
